cr_huf_comp_st_long_disp: RTL
=============================

# cr_huf_comp_st_long_disp

Frame dispatcher and read-order tracker for the pair of long-symbol table builders (ST1/ST2) in the Huffman compressor. It takes one long-symbol frame stream from the histogram stage and steers each whole frame to one builder, ping-pong by default with fallback when a builder is out of credit. It also records dispatch order so the downstream sequence-assembler (SA) reads finished tables in frame order. Symbol data fields fan out to both builders outside this block; the dispatcher only gates `val` and back-pressure.

## Interface
- MAX_OUTSTANDING, 2, frames per builder dispatched but not yet read by SA (1..4)
- clk  in  1  clock; one clock domain
- rst  in  1  asynchronous, active-high reset
- in_val  in  1  upstream symbol beat valid
- in_eob  in  1  last beat of frame (qualified by in_val)
- in_not_ready  out  1  back-pressure to upstream
- st1_val / st2_val  out  1  per-builder beat valid
- st1_not_ready / st2_not_ready  in  1  builder back-pressure
- st1_table_rdy / st2_table_rdy  in  1  builder has a finished table for SA
- sa_read_done  in  1  one-cycle pulse: SA finished reading the head table
- sa_sel  out  1  builder SA must read next (0=ST1, 1=ST2)
- sa_sel_vld  out  1  order FIFO non-empty
- sa_rd_rdy  out  1  sa_sel_vld & table_rdy of selected builder
- frame_dispatched  out  1  one-cycle pulse per frame start
- err_underflow  out  1  sticky: sa_read_done with empty FIFO

## Operation
- FSM: IDLE (no frame open), SEND (frame open, locked to `cur`).
- Eligibility: eligible[n] = outstanding[n] < MAX_OUTSTANDING.
- IDLE choice: preferred builder `pref` if eligible and its not_ready low; else the other if eligible and not_ready low; else none.
- accept = in_val & ~in_not_ready.
- IDLE: in_not_ready = (no choice). On accept: cur<=choice, outstanding[choice]++, frame_dispatched=1; if in_eob stay IDLE (single-beat frame), else go SEND.
- SEND: in_not_ready = stN_not_ready of cur. On accept with in_eob → IDLE.
- stN_val = accept & (selected builder == N); never both high.
- Frame end (accept & in_eob, either state): push cur into order FIFO; pref <= ~cur.
- Order FIFO: depth 2*MAX_OUTSTANDING, 1-bit entries; never overflows because occupancy ≤ total outstanding. Head drives sa_sel.
- sa_read_done with FIFO non-empty: pop; outstanding[head]--. Empty: ignored, err_underflow set until reset.
- Same-cycle inc and dec on one builder: net unchanged. Same-cycle push and pop: occupancy unchanged, pushed entry ordered behind head.
- in_eob without in_val ignored; upstream holds in_val/in_eob stable while in_not_ready.

## Timing
- Reset values: state IDLE, pref=ST1, cur=ST1, outstanding=0, FIFO empty, sa_sel=0, sa_sel_vld=0, sa_rd_rdy=0, frame_dispatched=0, err_underflow=0; in_not_ready=0 and stN_val=0 combinationally after reset.
- stN_val, in_not_ready, sa_rd_rdy: combinational, zero latency.
- sa_sel, sa_sel_vld: registered; entry visible at head the cycle after frame-end push.
- frame_dispatched: registered, one cycle after frame-start accept.
- Credit freed by sa_read_done usable for selection next cycle.
- Reset mid-frame: open frame abandoned, all state to reset values; builders are reset by the same rst.

## Structure
- Shared package cr_huf_compPKG: enum e_st_long_disp_state {IDLE, SEND}; typedef e_st_sel (ST1=0, ST2=1).
- Sub-module cr_huf_comp_st_long_ord_fifo: 1-bit-wide synchronous FIFO, parameterised depth, push/pop/empty/head.
- Counters: $clog2(MAX_OUTSTANDING+1) bits each.

## Test plan
- Four 3-beat frames, both builders ready, SA reading promptly → frames to ST1,ST2,ST1,ST2; sa_sel sequence 0,1,0,1.
- MAX_OUTSTANDING=2, SA never reads, six frames → frames 1–4 alternate; frame 5 held with in_not_ready=1, no stN_val; after one sa_read_done (head ST1) frame 5 goes to ST1 the cycle after.
- st2_not_ready held high at frame start with pref=ST2 → frame goes to ST1; pref after it = ST2.
- st1_not_ready pulses mid-frame on ST1 → in_not_ready mirrors it, st2_val stays 0, beat count on ST1 exact.
- Single-beat frames (in_eob on every beat) back-to-back with sa_read_done same cycle as push → no lost/duplicate FIFO entries, outstanding returns to 0.
- sa_read_done on empty FIFO → err_underflow=1 sticky; rst asserted mid-frame → IDLE, sa_sel_vld=0, err_underflow=0, next frame to ST1.

Source files
------------

// File: rtl/cr_huf_comp_st_long_disp_pkg.sv
// Shared types for the long-symbol frame dispatcher.
//   e_st_long_disp_state : dispatcher FSM state (IDLE = no frame open, SEND = frame open)
//   e_st_sel             : builder select, ST1 = 0, ST2 = 1 (matches the sa_sel encoding)
//   other_st()           : the builder that is not the argument
package cr_huf_compPKG;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } e_st_long_disp_state;

  typedef enum logic {
    ST1 = 1'b0,
    ST2 = 1'b1
  } e_st_sel;

  function automatic e_st_sel other_st(input e_st_sel s);
    return (s == ST1) ? ST2 : ST1;
  endfunction

endpackage

// File: rtl/cr_huf_comp_st_long_disp_if.sv
// Bundle of the dispatcher's handshake and status signals.
//   Upstream : in_val, in_eob -> dispatcher; in_not_ready <- dispatcher
//   Builders : st1_val/st2_val <- dispatcher; st*_not_ready, st*_table_rdy -> dispatcher
//   SA       : sa_read_done -> dispatcher; sa_sel, sa_sel_vld, sa_rd_rdy <- dispatcher
//   Status   : frame_dispatched, err_underflow <- dispatcher
//
// Handshake: a beat transfers on every clock edge where val is high and
// not_ready is low (val & ~not_ready). The sender holds val and eob stable
// while not_ready is high; not_ready may change freely while val is low.
// The 'slave' modport is the dispatcher's view; 'master' is everything around it.
interface cr_huf_comp_st_long_disp_if;
  logic in_val;
  logic in_eob;
  logic in_not_ready;
  logic st1_val;
  logic st2_val;
  logic st1_not_ready;
  logic st2_not_ready;
  logic st1_table_rdy;
  logic st2_table_rdy;
  logic sa_read_done;
  logic sa_sel;
  logic sa_sel_vld;
  logic sa_rd_rdy;
  logic frame_dispatched;
  logic err_underflow;

  modport master (
    output in_val, in_eob, st1_not_ready, st2_not_ready,
           st1_table_rdy, st2_table_rdy, sa_read_done,
    input  in_not_ready, st1_val, st2_val, sa_sel, sa_sel_vld,
           sa_rd_rdy, frame_dispatched, err_underflow
  );

  modport slave (
    input  in_val, in_eob, st1_not_ready, st2_not_ready,
           st1_table_rdy, st2_table_rdy, sa_read_done,
    output in_not_ready, st1_val, st2_val, sa_sel, sa_sel_vld,
           sa_rd_rdy, frame_dispatched, err_underflow
  );
endinterface

// File: rtl/cr_huf_comp_st_long_ord_fifo.sv
// 1-bit-wide synchronous FIFO that records which builder each completed frame
// went to, so SA reads tables in dispatch order.
//   clk, rst  : clock, asynchronous active-high reset
//   push      : write push_data at the tail (caller guarantees not full)
//   pop       : drop the head entry; ignored while empty
//   empty     : no entries stored
//   head      : oldest entry (driven from registers)
module cr_huf_comp_st_long_ord_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic push_data,
  input  logic pop,
  output logic empty,
  output logic head
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pop_ok;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    pop_ok   = pop & (cnt_q != '0);
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end
    if (pop_ok) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    case ({push, pop_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_ptr_q];
endmodule

// File: rtl/cr_huf_comp_st_long_disp.sv
// Long-symbol frame dispatcher for the ST1/ST2 table builders. Each whole
// frame is steered to one builder (ping-pong, falling back to the other
// builder when the preferred one is busy or out of credit), and the dispatch
// order is recorded so SA reads finished tables in frame order.
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : handshake/status bundle (slave view), see the interface file
//   dbg_state : current FSM state, for observation only
module cr_huf_comp_st_long_disp
  import cr_huf_compPKG::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  cr_huf_comp_st_long_disp_if.slave  bus,
  output e_st_long_disp_state        dbg_state
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

  e_st_long_disp_state state_q, state_d;
  e_st_sel             cur_q, cur_d;
  e_st_sel             pref_q, pref_d;
  logic [CW-1:0]       out1_q, out1_d;
  logic [CW-1:0]       out2_q, out2_d;
  logic                fd_q, fd_d;
  logic                err_q, err_d;

  e_st_sel sel;
  logic    accept;
  logic    frame_start, frame_end;
  logic    fifo_empty, fifo_head, pop;
  logic    ok1, ok2, ok_pref, ok_oth;
  logic    inc1, dec1, inc2, dec2;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cur_q   <= ST1;
      pref_q  <= ST1;
      out1_q  <= '0;
      out2_q  <= '0;
      fd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      pref_q  <= pref_d;
      out1_q  <= out1_d;
      out2_q  <= out2_d;
      fd_q    <= fd_d;
      err_q   <= err_d;
    end
  end

  // Output logic: builder selection and back-pressure, all zero latency.
  always_comb begin
    ok1     = (out1_q < MAX_C) & ~bus.st1_not_ready;
    ok2     = (out2_q < MAX_C) & ~bus.st2_not_ready;
    ok_pref = (pref_q == ST1) ? ok1 : ok2;
    ok_oth  = (pref_q == ST1) ? ok2 : ok1;
    sel     = cur_q;
    bus.in_not_ready = 1'b0;
    if (state_q == IDLE) begin
      // Between frames: take the preferred builder, else the other one.
      sel              = ok_pref ? pref_q : other_st(pref_q);
      bus.in_not_ready = ~(ok_pref | ok_oth);
    end else begin
      // Mid-frame: locked to cur, so only its back-pressure matters.
      bus.in_not_ready = (cur_q == ST1) ? bus.st1_not_ready : bus.st2_not_ready;
    end
    accept           = bus.in_val & ~bus.in_not_ready;
    bus.st1_val      = accept & (sel == ST1);
    bus.st2_val      = accept & (sel == ST2);
    bus.sa_sel_vld   = ~fifo_empty;
    bus.sa_sel       = fifo_head & ~fifo_empty;
    bus.sa_rd_rdy    = ~fifo_empty & (fifo_head ? bus.st2_table_rdy : bus.st1_table_rdy);
    bus.frame_dispatched = fd_q;
    bus.err_underflow    = err_q;
  end

  // Next-state logic
  always_comb begin
    frame_start = accept & (state_q == IDLE);
    frame_end   = accept & bus.in_eob;
    pop         = bus.sa_read_done & ~fifo_empty;

    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_start && !bus.in_eob) state_d = SEND;
      SEND:    if (frame_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cur_d  = frame_start ? sel : cur_q;
    pref_d = frame_end ? other_st(sel) : pref_q;
    fd_d   = frame_start;
    err_d  = err_q | (bus.sa_read_done & fifo_empty);

    // Credit is taken at frame start and returned when SA finishes the
    // table; both on one builder in the same cycle cancel out.
    inc1 = frame_start & (sel == ST1);
    inc2 = frame_start & (sel == ST2);
    dec1 = pop & ~fifo_head;
    dec2 = pop & fifo_head;
    out1_d = out1_q;
    out2_d = out2_q;
    if (inc1 && !dec1) out1_d = out1_q + CW'(1);
    if (dec1 && !inc1) out1_d = out1_q - CW'(1);
    if (inc2 && !dec2) out2_d = out2_q + CW'(1);
    if (dec2 && !inc2) out2_d = out2_q - CW'(1);
  end

  // Occupancy never exceeds total outstanding credit, so 2*MAX cannot overflow.
  cr_huf_comp_st_long_ord_fifo #(
    .DEPTH (2 * MAX_OUTSTANDING)
  ) u_ord_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (frame_end),
    .push_data (sel),
    .pop       (pop),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  assign dbg_state = state_q;
endmodule
